axi_read_arbiter: RTL and testbench

- Shares one AXI slave read port between NUM_MASTERS read masters. Each master is the read-master block already in the codebase.
- Round-robin arbitration of the read-address (AR) channel, one transaction in flight at a time.
- Routes the read-data (R) channel back to the granted master until the RLAST beat completes.
- Sits between the per-device read masters and the memory slave.

---
 rtl/axi_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/axi_read_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and arbiter state type for the read arbiter slice.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Pure combinational round-robin grant: the search starts one past ptr_i and wraps.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int IdxW = $clog2(N);

  logic            found_s;
  logic [IdxW-1:0] idx_s;

  // Rotating priority search; the first requester after the pointer wins.
  always_comb begin
    int cand;
    found_s = 1'b0;
    idx_s   = '0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!found_s && req_i[cand]) begin
        found_s = 1'b1;
        idx_s   = IdxW'(cand);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_o = found_s;
  assign idx_o = idx_s;
  assign gnt_o = found_s ? ({{(N-1){1'b0}}, 1'b1} << idx_s) : {N{1'b0}};

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin sharing of one AXI read slave port between NUM_MASTERS masters.
// Optional R-channel watchdog enabled by defining AXI_RD_ARB_TIMEOUT_EN.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int BusWidth    = 32,
  parameter int TagBits     = 4,
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [NUM_MASTERS-1:0]         m_arvalid,
  output logic [NUM_MASTERS-1:0]         m_arready,
  input  logic [NUM_MASTERS*TagBits-1:0] m_arid,
  input  logic [NUM_MASTERS*BusWidth-1:0] m_araddr,
  input  logic [NUM_MASTERS*4-1:0]       m_arlen,
  input  logic [NUM_MASTERS*2-1:0]       m_arsize,
  input  logic [NUM_MASTERS*2-1:0]       m_arburst,
  output logic [NUM_MASTERS-1:0]         m_rvalid,
  input  logic [NUM_MASTERS-1:0]         m_rready,
  output logic [BusWidth-1:0]            m_rdata,
  output logic [TagBits-1:0]             m_rid,
  output logic [1:0]                     m_rresp,
  output logic                           m_rlast,
  output logic                           S_ARVALID,
  input  logic                           S_ARREADY,
  output logic [TagBits-1:0]             S_ARID,
  output logic [BusWidth-1:0]            S_ARADDR,
  output logic [3:0]                     S_ARLEN,
  output logic [1:0]                     S_ARSIZE,
  output logic [1:0]                     S_ARBURST,
  input  logic                           S_RVALID,
  output logic                           S_RREADY,
  input  logic [TagBits-1:0]             S_RID,
  input  logic [BusWidth-1:0]            S_RDATA,
  input  logic [1:0]                     S_RRESP,
  input  logic                           S_RLAST,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_idx
);

  localparam int IdxW = $clog2(NUM_MASTERS);

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]       grant_idx_q, grant_idx_d;
  logic                  s_arvalid_q, s_arvalid_d;
  logic [TagBits-1:0]    ar_id_q, ar_id_d;
  logic [BusWidth-1:0]   ar_addr_q, ar_addr_d;
  logic [3:0]            ar_len_q, ar_len_d;
  logic [1:0]            ar_size_q, ar_size_d;
  logic [1:0]            ar_burst_q, ar_burst_d;

  logic [NUM_MASTERS-1:0] req_gnt_s;
  logic [NUM_MASTERS-1:0] grant_oh_s;
  logic [IdxW-1:0]        req_idx_s;
  logic                   req_any_s;
  logic                   tmo_hit_s;

  rr_arbiter #(.N(NUM_MASTERS)) u_rr_arbiter (
    .req_i (m_arvalid),
    .ptr_i (rr_ptr_q),
    .gnt_o (req_gnt_s),
    .idx_o (req_idx_s),
    .any_o (req_any_s)
  );

  assign grant_oh_s = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << grant_idx_q;

`ifdef AXI_RD_ARB_TIMEOUT_EN
  localparam int TmoW = $clog2(TIMEOUT + 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Idle-cycle count while waiting on R beats; any completed beat restarts it.
  always_comb begin
    if (state_q == ARB_DATA) begin
      if (S_RVALID && S_RREADY) begin
        tmo_cnt_d = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
      end
    end else begin
      tmo_cnt_d = '0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign tmo_hit_s = (state_q == ARB_DATA) && (tmo_cnt_q == TmoW'(TIMEOUT));
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state, capture and channel routing.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    s_arvalid_d = s_arvalid_q;
    ar_id_d     = ar_id_q;
    ar_addr_d   = ar_addr_q;
    ar_len_d    = ar_len_q;
    ar_size_d   = ar_size_q;
    ar_burst_d  = ar_burst_q;
    m_arready   = '0;
    m_rvalid    = '0;
    S_RREADY    = 1'b0;
    m_rdata     = S_RDATA;
    m_rid       = S_RID;
    m_rresp     = S_RRESP;
    m_rlast     = S_RLAST;

    case (state_q)
      ARB_IDLE: begin
        if (req_any_s) begin
          m_arready   = req_gnt_s;
          ar_id_d     = m_arid[req_idx_s*TagBits +: TagBits];
          ar_addr_d   = m_araddr[req_idx_s*BusWidth +: BusWidth];
          ar_len_d    = m_arlen[req_idx_s*4 +: 4];
          ar_size_d   = m_arsize[req_idx_s*2 +: 2];
          ar_burst_d  = m_arburst[req_idx_s*2 +: 2];
          grant_idx_d = req_idx_s;
          s_arvalid_d = 1'b1;
          state_d     = ARB_ADDR;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ADDR: begin
        if (S_ARREADY) begin
          s_arvalid_d = 1'b0;
          state_d     = ARB_DATA;
        end else begin
          state_d = ARB_ADDR;
        end
      end
      ARB_DATA: begin
        if (tmo_hit_s) begin
          // Synthesised error beat closes the transaction without the slave.
          m_rvalid = grant_oh_s;
          m_rresp  = RESP_SLVERR;
          m_rlast  = 1'b1;
          m_rid    = ar_id_q;
          rr_ptr_d = grant_idx_q;
          state_d  = ARB_IDLE;
        end else begin
          m_rvalid = S_RVALID ? grant_oh_s : '0;
          S_RREADY = m_rready[grant_idx_q];
          if (S_RVALID && m_rready[grant_idx_q] && S_RLAST) begin
            rr_ptr_d = grant_idx_q;
            state_d  = ARB_IDLE;
          end else begin
            state_d = ARB_DATA;
          end
        end
      end
      default: begin
        state_d     = ARB_IDLE;
        s_arvalid_d = 1'b0;
      end
    endcase
  end

  // Arbiter state, pointer and captured AR payload.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= IdxW'(NUM_MASTERS - 1);
      grant_idx_q <= '0;
      s_arvalid_q <= 1'b0;
      ar_id_q     <= '0;
      ar_addr_q   <= '0;
      ar_len_q    <= 4'd0;
      ar_size_q   <= 2'd0;
      ar_burst_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      s_arvalid_q <= s_arvalid_d;
      ar_id_q     <= ar_id_d;
      ar_addr_q   <= ar_addr_d;
      ar_len_q    <= ar_len_d;
      ar_size_q   <= ar_size_d;
      ar_burst_q  <= ar_burst_d;
    end
  end

  assign S_ARVALID = s_arvalid_q;
  assign S_ARID    = ar_id_q;
  assign S_ARADDR  = ar_addr_q;
  assign S_ARLEN   = ar_len_q;
  assign S_ARSIZE  = ar_size_q;
  assign S_ARBURST = ar_burst_q;
  assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed scoreboard bench for axi_read_arbiter (two masters, slave driven by the bench).
module tb_axi_read_arbiter;

  localparam int BW = 32;
  localparam int TB = 4;
  localparam int NM = 2;

  logic           ACLK;
  logic           ARESETn;
  logic [NM-1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
  logic [NM*TB-1:0] m_arid;
  logic [NM*BW-1:0] m_araddr;
  logic [NM*4-1:0]  m_arlen;
  logic [NM*2-1:0]  m_arsize, m_arburst;
  logic [BW-1:0]  m_rdata;
  logic [TB-1:0]  m_rid;
  logic [1:0]     m_rresp;
  logic           m_rlast;
  logic           S_ARVALID, S_ARREADY;
  logic [TB-1:0]  S_ARID;
  logic [BW-1:0]  S_ARADDR;
  logic [3:0]     S_ARLEN;
  logic [1:0]     S_ARSIZE, S_ARBURST;
  logic           S_RVALID, S_RREADY;
  logic [TB-1:0]  S_RID;
  logic [BW-1:0]  S_RDATA;
  logic [1:0]     S_RRESP;
  logic           S_RLAST;
  logic [0:0]     grant_idx;

  int errors = 0;
  int checks = 0;
  logic [BW-1:0] sb[$];

  axi_read_arbiter #(.BusWidth(BW), .TagBits(TB), .NUM_MASTERS(NM), .TIMEOUT(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY), .S_ARID(S_ARID), .S_ARADDR(S_ARADDR),
    .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY), .S_RID(S_RID), .S_RDATA(S_RDATA),
    .S_RRESP(S_RRESP), .S_RLAST(S_RLAST), .grant_idx(grant_idx)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ar(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    m_arid[m*TB +: TB]   = id;
    m_araddr[m*BW +: BW] = addr;
    m_arlen[m*4 +: 4]    = len;
    m_arsize[m*2 +: 2]   = 2'b10;
    m_arburst[m*2 +: 2]  = 2'b01;
    m_arvalid[m]         = 1'b1;
  endtask

  // Request from master m, expect grant vector exp_rdy, stall the slave AR for 'stall' cycles.
  task automatic do_ar(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [1:0] exp_rdy, input int stall);
    set_ar(m, id, addr, len);
    #1;
    chk("arready_grant", {62'd0, m_arready}, {62'd0, exp_rdy});
    tick();
    m_arvalid[m] = 1'b0;
    #1;
    chk("s_arvalid", {63'd0, S_ARVALID}, 64'd1);
    chk("s_araddr", {32'd0, S_ARADDR}, {32'd0, addr});
    chk("s_arid", {60'd0, S_ARID}, {60'd0, id});
    chk("s_arlen", {60'd0, S_ARLEN}, {60'd0, len});
    chk("grant_idx", {63'd0, grant_idx}, 64'(m));
    chk("arready_in_addr", {62'd0, m_arready}, 64'd0);
    for (int k = 0; k < stall; k++) begin
      S_RVALID = 1'b1;
      m_rready = 2'b11;
      #1;
      chk("ar_hold_valid", {63'd0, S_ARVALID}, 64'd1);
      chk("ar_hold_addr", {32'd0, S_ARADDR}, {32'd0, addr});
      chk("rready_in_addr", {63'd0, S_RREADY}, 64'd0);
      tick();
    end
    S_RVALID  = 1'b0;
    m_rready  = 2'b00;
    S_ARREADY = 1'b1;
    tick();
    S_ARREADY = 1'b0;
    #1;
    chk("arvalid_drop", {63'd0, S_ARVALID}, 64'd0);
  endtask

  // Slave sends n beats to granted master g; stop after 'stop' completed beats.
  task automatic do_burst(input int g, input int n, input int stop, input logic [31:0] base, input bit toggle);
    int i;
    int cyc;
    logic rr;
    logic [31:0] exp;
    for (int k = 0; k < n; k++) sb.push_back(base + 32'(k));
    i = 0;
    cyc = 0;
    while (i < stop && cyc < 64) begin
      rr = toggle ? (cyc % 2 == 0) : 1'b1;
      m_rready    = 2'b11;
      m_rready[g] = rr;
      S_RVALID = 1'b1;
      S_RDATA  = base + 32'(i);
      S_RLAST  = (i == n - 1);
      S_RID    = 4'hA;
      S_RRESP  = 2'b00;
      #1;
      chk("rready_mirror", {63'd0, S_RREADY}, {63'd0, rr});
      chk("rvalid_route", {62'd0, m_rvalid}, 64'(2'b01 << g));
      if (rr) begin
        chk("rlast", {63'd0, m_rlast}, 64'(i == n - 1));
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          chk("rdata", {32'd0, m_rdata}, {32'd0, exp});
        end
        i++;
      end
      tick();
      cyc++;
    end
    chk("burst_done_in_budget", 64'(i), 64'(stop));
    S_RVALID = 1'b0;
    S_RLAST  = 1'b0;
    m_rready = 2'b00;
  endtask

  initial begin
    ARESETn = 1'b0;
    m_arvalid = '0; m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    m_rready = '0; S_ARREADY = 1'b0; S_RVALID = 1'b0; S_RID = '0; S_RDATA = '0;
    S_RRESP = '0; S_RLAST = 1'b0;
    repeat (3) tick();
    chk("rst_s_arvalid", {63'd0, S_ARVALID}, 64'd0);
    chk("rst_s_araddr", {32'd0, S_ARADDR}, 64'd0);
    chk("rst_grant_idx", {63'd0, grant_idx}, 64'd0);
    chk("rst_m_rvalid", {62'd0, m_rvalid}, 64'd0);
    ARESETn = 1'b1;
    tick();

    // Single request from master 0, four beats.
    do_ar(0, 4'h5, 32'h100, 4'd3, 2'b01, 0);
    do_burst(0, 4, 4, 32'hA0, 1'b0);
    chk("sb_drained_t1", 64'(sb.size()), 64'd0);
    S_RVALID = 1'b1;
    m_rready = 2'b11;
    #1;
    chk("idle_no_rready", {63'd0, S_RREADY}, 64'd0);
    chk("idle_no_rvalid", {62'd0, m_rvalid}, 64'd0);
    S_RVALID = 1'b0;
    m_rready = 2'b00;

    // Simultaneous requests after reset: master 0 then master 1.
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    tick();
    set_ar(1, 4'h2, 32'h200, 4'd1);
    do_ar(0, 4'h1, 32'h180, 4'd1, 2'b01, 0);
    do_burst(0, 2, 2, 32'hB0, 1'b0);
    do_ar(1, 4'h2, 32'h200, 4'd1, 2'b10, 0);
    do_burst(1, 2, 2, 32'hC0, 1'b0);
    set_ar(1, 4'h3, 32'h280, 4'd0);
    do_ar(0, 4'h4, 32'h2C0, 4'd0, 2'b01, 0);
    m_arvalid = 2'b00;
    do_burst(0, 1, 1, 32'hD0, 1'b0);

    // AR backpressure on master 1.
    do_ar(1, 4'h3, 32'h300, 4'd2, 2'b10, 5);
    do_burst(1, 3, 3, 32'hE0, 1'b0);

    // R backpressure on master 0.
    do_ar(0, 4'h6, 32'h400, 4'd3, 2'b01, 0);
    do_burst(0, 4, 4, 32'hF0, 1'b1);
    chk("sb_drained_t4", 64'(sb.size()), 64'd0);

    // Reset mid-burst on master 1.
    do_ar(1, 4'h7, 32'h500, 4'd3, 2'b10, 0);
    do_burst(1, 4, 2, 32'h50, 1'b0);
    S_RVALID = 1'b1;
    m_rready = 2'b11;
    ARESETn  = 1'b0;
    #1;
    chk("mid_rst_rvalid", {62'd0, m_rvalid}, 64'd0);
    chk("mid_rst_rready", {63'd0, S_RREADY}, 64'd0);
    chk("mid_rst_arvalid", {63'd0, S_ARVALID}, 64'd0);
    chk("mid_rst_grant", {63'd0, grant_idx}, 64'd0);
    sb.delete();
    tick();
    S_RVALID = 1'b0;
    m_rready = 2'b00;
    ARESETn  = 1'b1;
    tick();
    set_ar(1, 4'h8, 32'h600, 4'd0);
    do_ar(0, 4'h9, 32'h640, 4'd0, 2'b01, 0);
    m_arvalid = 2'b00;
    do_burst(0, 1, 1, 32'h60, 1'b0);

`ifdef AXI_RD_ARB_TIMEOUT_EN
    // Slave never answers: watchdog issues one SLVERR last beat.
    do_ar(1, 4'h9, 32'h700, 4'd1, 2'b10, 0);
    m_rready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("tmo_wait_rvalid", {62'd0, m_rvalid}, 64'd0);
      tick();
    end
    #1;
    chk("tmo_rvalid", {62'd0, m_rvalid}, 64'd2);
    chk("tmo_rresp", {62'd0, m_rresp}, 64'd2);
    chk("tmo_rlast", {63'd0, m_rlast}, 64'd1);
    chk("tmo_rid", {60'd0, m_rid}, 64'h9);
    chk("tmo_rready", {63'd0, S_RREADY}, 64'd0);
    tick();
    m_rready = 2'b00;
    m_arvalid[0] = 1'b1;
    #1;
    chk("tmo_back_idle", {62'd0, m_arready}, 64'd1);
    m_arvalid = 2'b00;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
